mem_main_pipe: RTL and testbench
================================

// Module: mem_main_pipe
// PURPOSE
//  Parametrised main/data memory with a valid/ready request port and a pipelined read-response port.
//  Byte-addressed, big-endian storage; supports byte and full-word accesses.
//  Clears itself after reset with a sequential sweep.
//  Sits between the MEM pipeline stage and storage; halt_sys freezes it with the rest of the core.
// PARAMETERS
//  ADDR_W    16  byte-address width; memory holds 2**ADDR_W bytes
//  DATA_W    16  word width in bits; multiple of 8, >=16; NB = DATA_W/8 bytes/word
//  READ_LAT  1   accept-to-rsp_valid latency in cycles, legal 1..4
//  CLEAR_ON_RST 1 1: sweep memory to zero after reset; 0: skip CLEAR, contents kept
// PORTS
//  clockg     in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  halt_sys   in   1       global halt; freezes all state
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_size   in   1       0 = byte, 1 = word (NB bytes)
//  req_addr   in   ADDR_W  byte address of first (most significant) byte
//  req_wdata  in   DATA_W  write data; byte access uses [7:0]
//  rsp_valid  out  1       read data valid (one pulse per accepted read)
//  rsp_rdata  out  DATA_W  read data; byte reads zero-extended
//  clear_busy out  1       CLEAR sweep in progress
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, clear_busy=CLEAR_ON_RST; read pipeline flushed.
//  Reset releases into CLEAR (CLEAR_ON_RST=1) or IDLE (CLEAR_ON_RST=0).
//  FSM:
//   CLEAR: one byte zeroed per unhalted cycle, address 0 upward; clear_busy=1, req_ready=0.
//          After byte 2**ADDR_W-1 -> IDLE.
//   IDLE:  req_ready = !halt_sys. Accepted = req_valid & req_ready; one request per cycle, no bubbles.
//  Rules:
//   - Word layout: byte addr+i holds bits [DATA_W-1-8i -: 8], i=0..NB-1; addresses wrap modulo 2**ADDR_W.
//   - Any req_addr is legal; no alignment requirement.
//   - Write: storage updated at the accepting edge; byte write touches only addr; no response generated.
//   - Read: storage sampled at the accepting edge; rsp_valid is high exactly READ_LAT unhalted cycles later.
//     Responses are returned in order.
//   - Read-after-write: a read accepted the cycle after a write to an overlapping byte returns new data.
//   - rsp_rdata holds its last value until the next response; rsp_valid is a single-cycle pulse.
//   - halt_sys=1: no accept, no storage write, CLEAR address frozen, read pipeline frozen.
//     rsp_valid/rsp_rdata hold their current values for the whole halt and resume on release.
//   - req_valid with req_ready=0: ignored; the requester must hold the request.
//   - rst mid-operation: in-flight reads dropped (never respond), pending write not performed.
//     CLEAR restarts from 0.
// TESTING (ADDR_W=6, DATA_W=16, READ_LAT=2, CLEAR_ON_RST=1 unless stated)
//  1 Preload nonzero, pulse rst -> clear_busy=1, req_ready=0 for 64 cycles; word read @0x10 -> 0x0000 2 cycles after accept.
//  2 Word write 0xBEEF @0x04; byte read @0x05 -> 0x00EF; word read @0x04 -> 0xBEEF; byte read @0x04 -> 0x00BE.
//  3 Wrap: word write 0x1234 @0x3F; byte read @0x00 -> 0x0034; byte read @0x3F -> 0x0012.
//  4 Back-to-back: write 0xA5A5 @0x08, then reads @0x08,0x0A,0x08,0x09 on consecutive cycles ->
//    4 consecutive rsp_valid pulses: 0xA5A5, 0x0000, 0xA5A5, 0xA500.
//  5 Read @0x08 accepted, halt_sys=1 for 3 cycles next cycle -> rsp_valid 3 cycles late.
//    Write presented during halt -> req_ready=0, memory unchanged.
//  6 rst asserted 1 cycle after a read accept -> rsp_valid never pulses for that read; CLEAR restarts;
//    CLEAR_ON_RST=0 variant: rst keeps contents, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/mem_main_pipe.sv
// mem_main_pipe: byte-addressed big-endian main memory, valid/ready
// request port, pipelined in-order read responses, post-reset clear.
//
// Ports:
//   clockg, rst        clock; asynchronous active-high reset
//   halt_sys           freezes every piece of state while high
//   req_valid/ready    request handshake (accept = valid & ready)
//   req_we, req_size   1 = write / 0 = read; 0 = byte / 1 = word
//   req_addr           byte address of the most significant byte
//   req_wdata          write data; byte writes use [7:0]
//   rsp_valid          one-cycle pulse READ_LAT cycles after a read
//   rsp_rdata          read data, byte reads zero-extended; held
//   clear_busy         clear sweep in progress
module mem_main_pipe #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int READ_LAT     = 1,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clockg,
   input  logic              rst,
   input  logic              halt_sys,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              clear_busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] data;
   } rsp_stage_t;

   localparam state_t RST_STATE = CLEAR_ON_RST ? CLEAR : IDLE;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] clr_addr_nxt;
   logic              clr_go;

   logic [7:0]        mem [DEPTH];
   rsp_stage_t        pipe [READ_LAT];

   logic              accept;
   logic              acc_rd;
   logic              acc_wr;
   logic [ADDR_W-1:0] byte_addr [NB];
   logic [7:0]        wr_byte [NB];
   logic [NB-1:0]     wr_en;
   logic [DATA_W-1:0] rd_word;

   // ---------------- control FSM ----------------
   always_ff @(posedge clockg or posedge rst) begin
      if (rst) begin
         state    <= RST_STATE;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clear_busy   = 1'b0;
      req_ready    = 1'b0;
      clr_go       = 1'b0;
      unique case (state)
         CLEAR: begin
            clear_busy = 1'b1;
            clr_go     = !halt_sys;
            if (clr_go) begin
               clr_addr_nxt = clr_addr + ADDR_W'(1);
               if (&clr_addr)
                  state_nxt = IDLE;
            end
         end
         IDLE: begin
            // rst term keeps ready low while reset is held
            req_ready = !halt_sys && !rst;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   assign accept = req_valid && req_ready;
   assign acc_rd = accept && !req_we;
   assign acc_wr = accept && req_we;

   // ---------------- byte lanes ----------------
   // Lane i is byte req_addr+i, wrapping; it carries
   // the i-th most significant byte of the word.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NB; i++) begin
         byte_addr[i] = req_addr + ADDR_W'(i);
         wr_byte[i]   = req_size ?
                        req_wdata[DATA_W-1-8*i -: 8] :
                        req_wdata[7:0];
         wr_en[i]     = acc_wr && (req_size || i == 0);
      end
      if (req_size) begin
         for (int i = 0; i < NB; i++)
            rd_word[DATA_W-1-8*i -: 8] = mem[byte_addr[i]];
      end else begin
         rd_word = DATA_W'(mem[req_addr]);
      end
   end

   // ---------------- storage ----------------
   // No reset on the array; the rst term drops a
   // write whose edge coincides with reset.
   always_ff @(posedge clockg) begin
      if (!rst) begin
         if (clr_go)
            mem[clr_addr] <= '0;
         for (int i = 0; i < NB; i++)
            if (wr_en[i])
               mem[byte_addr[i]] <= wr_byte[i];
      end
   end

   // ---------------- read pipeline ----------------
   // Data in each stage only moves with a valid
   // token, so the last stage keeps the most recent
   // response and doubles as the rsp_rdata hold.
   always_ff @(posedge clockg or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++)
            pipe[i] <= '0;
      end else if (!halt_sys) begin
         pipe[0].vld <= acc_rd;
         if (acc_rd)
            pipe[0].data <= rd_word;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe[i].vld <= pipe[i-1].vld;
            if (pipe[i-1].vld)
               pipe[i].data <= pipe[i-1].data;
         end
      end
   end

   assign rsp_valid = pipe[READ_LAT-1].vld;
   assign rsp_rdata = pipe[READ_LAT-1].data;

endmodule

// File: tb/tb_mem_main_pipe.sv
// tb_mem_main_pipe: directed bench for mem_main_pipe.
// Two instances share stimulus: clearing and non-clearing.
module tb_mem_main_pipe;

   localparam int AW  = 6;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic          clockg    = 1'b0;
   logic          rst       = 1'b1;
   logic          halt_sys  = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we    = 1'b0;
   logic          req_size  = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;

   logic          c_ready, c_valid, c_busy;
   logic [DW-1:0] c_rdata;
   logic          n_ready, n_valid, n_busy;
   logic [DW-1:0] n_rdata;

   logic          use_nc = 1'b0;
   logic          o_ready, o_valid, o_busy;
   logic [DW-1:0] o_rdata;

   int n_run  = 0;
   int n_fail = 0;

   logic [AW-1:0] t4_addr [5] = '{6'h08, 6'h08, 6'h0A, 6'h08, 6'h09};
   logic [DW-1:0] t4_exp  [4] = '{16'hA5A5, 16'h0000, 16'hA5A5, 16'hA500};

   assign o_ready = use_nc ? n_ready : c_ready;
   assign o_valid = use_nc ? n_valid : c_valid;
   assign o_busy  = use_nc ? n_busy  : c_busy;
   assign o_rdata = use_nc ? n_rdata : c_rdata;

   mem_main_pipe #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .CLEAR_ON_RST(1'b1)
   ) dut (
      .clockg(clockg), .rst(rst), .halt_sys(halt_sys),
      .req_valid(req_valid), .req_ready(c_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(c_valid), .rsp_rdata(c_rdata), .clear_busy(c_busy)
   );

   mem_main_pipe #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .CLEAR_ON_RST(1'b0)
   ) dut_nc (
      .clockg(clockg), .rst(rst), .halt_sys(halt_sys),
      .req_valid(req_valid), .req_ready(n_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(n_valid), .rsp_rdata(n_rdata), .clear_busy(n_busy)
   );

   always #5 clockg = ~clockg;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clockg);
      #1;
   endtask

   // returns just after the accepting edge
   task automatic send(input logic we, input logic sz,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_addr  = a;
      req_wdata = d;
      #1;
      while (!o_ready && n < 200) begin
         cyc();
         n++;
      end
      if (!o_ready)
         chk("req_timeout", 32'd0, 32'd1);
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic rd(input string tag, input logic sz,
                     input logic [AW-1:0] a, input logic [DW-1:0] exp);
      send(1'b0, sz, a, '0);
      chk({tag, "_early"}, 32'(o_valid), 32'd0);
      cyc();
      chk({tag, "_vld"}, 32'(o_valid), 32'd1);
      chk(tag, 32'(o_rdata), 32'(exp));
   endtask

   task automatic clr_count(input string tag);
      int n   = 0;
      int rdy = 0;
      int rsp = 0;
      while (o_busy && n < 200) begin
         if (o_ready) rdy++;
         if (o_valid) rsp++;
         cyc();
         n++;
      end
      chk(tag, 32'(n), 32'd64);
      chk({tag, "_rdy"}, 32'(rdy), 32'd0);
      chk({tag, "_rsp"}, 32'(rsp), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      cyc();
      cyc();
      chk("rst_ready", 32'(c_ready), 32'd0);
      chk("rst_valid", 32'(c_valid), 32'd0);
      chk("rst_rdata", 32'(c_rdata), 32'd0);
      chk("rst_busy", 32'(c_busy), 32'd1);
      chk("rst_nc_busy", 32'(n_busy), 32'd0);
      chk("rst_nc_ready", 32'(n_ready), 32'd0);
      rst = 1'b0;
      clr_count("clr0");

      // test 1: preload, reset, clear sweep
      send(1'b1, 1'b1, 6'h10, 16'hFFFF);
      rd("pre_rd10", 1'b1, 6'h10, 16'hFFFF);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      clr_count("clr1");
      rd("t1_rd10", 1'b1, 6'h10, 16'h0000);

      // test 2: big-endian layout
      send(1'b1, 1'b1, 6'h04, 16'hBEEF);
      rd("t2_b05", 1'b0, 6'h05, 16'h00EF);
      rd("t2_w04", 1'b1, 6'h04, 16'hBEEF);
      rd("t2_b04", 1'b0, 6'h04, 16'h00BE);

      // test 3: address wrap
      send(1'b1, 1'b1, 6'h3F, 16'h1234);
      rd("t3_b00", 1'b0, 6'h00, 16'h0034);
      rd("t3_b3f", 1'b0, 6'h3F, 16'h0012);
      rd("t3_w3f", 1'b1, 6'h3F, 16'h1234);

      // byte write touches one byte only
      send(1'b1, 1'b0, 6'h05, 16'hFF11);
      rd("bw_w04", 1'b1, 6'h04, 16'hBE11);

      // test 4: write then back-to-back reads
      for (int k = 0; k < 7; k++) begin
         if (k < 5) begin
            req_valid = 1'b1;
            req_we    = (k == 0);
            req_size  = 1'b1;
            req_addr  = t4_addr[k];
            req_wdata = 16'hA5A5;
            #1;
            chk($sformatf("t4_rdy%0d", k), 32'(o_ready), 32'd1);
         end else begin
            req_valid = 1'b0;
         end
         cyc();
         if (k >= 2 && k <= 5) begin
            chk($sformatf("t4_vld%0d", k), 32'(o_valid), 32'd1);
            chk($sformatf("t4_dat%0d", k), 32'(o_rdata),
                32'(t4_exp[k-2]));
         end
         if (k == 6)
            chk("t4_end", 32'(o_valid), 32'd0);
      end

      // test 5: halt delays response, blocks writes
      send(1'b0, 1'b1, 6'h08, '0);
      halt_sys  = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 1'b1;
      req_addr  = 6'h08;
      req_wdata = 16'hFFFF;
      #1;
      chk("t5_rdy_halt", 32'(o_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("t5_hold%0d", k), 32'(o_valid), 32'd0);
      end
      halt_sys  = 1'b0;
      req_valid = 1'b0;
      cyc();
      chk("t5_late_vld", 32'(o_valid), 32'd1);
      chk("t5_late_dat", 32'(o_rdata), 32'hA5A5);
      cyc();
      chk("t5_pulse", 32'(o_valid), 32'd0);
      chk("t5_keep", 32'(o_rdata), 32'hA5A5);
      rd("t5_mem08", 1'b1, 6'h08, 16'hA5A5);

      // halt while rsp_valid is high holds it
      send(1'b0, 1'b1, 6'h04, '0);
      cyc();
      halt_sys = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk($sformatf("hh_vld%0d", k), 32'(o_valid), 32'd1);
         chk($sformatf("hh_dat%0d", k), 32'(o_rdata), 32'hBE11);
      end
      halt_sys = 1'b0;
      cyc();
      chk("hh_rel", 32'(o_valid), 32'd0);

      // test 6: reset drops in-flight read
      send(1'b0, 1'b1, 6'h08, '0);
      rst = 1'b1;
      #1;
      chk("t6_rst_vld", 32'(c_valid), 32'd0);
      chk("t6_rst_busy", 32'(c_busy), 32'd1);
      chk("t6_rst_nc_rdy", 32'(n_ready), 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_nc_rdy", 32'(n_ready), 32'd1);
      chk("t6_nc_busy", 32'(n_busy), 32'd0);
      chk("t6_nc_vld", 32'(n_valid), 32'd0);
      clr_count("t6_clr");
      rd("t6_rd08", 1'b1, 6'h08, 16'h0000);
      use_nc = 1'b1;
      rd("t6_nc_rd08", 1'b1, 6'h08, 16'hA5A5);
      rd("t6_nc_rd3f", 1'b1, 6'h3F, 16'h1234);
      use_nc = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
